// File: rtl/imem_loader.sv
// ============================================================================
// Module  : imem_loader
// Brief   : Boot-time byte-stream program loader driving the instruction
//           memory write port; holds the CPU in reset while loading.
//           Optional checksum byte enabled by IMEM_LOADER_CHECKSUM_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_loader #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             in_ready,
    output logic             wr_en,
    output logic [WIDTH-1:0] wr_addr,
    output logic [WIDTH-1:0] wr_data,
    output logic             cpu_hold,
    output logic             done,
    output logic             err
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HDR0 = 3'd1,
        S_HDR1 = 3'd2,
        S_DATA = 3'd3,
        S_CSUM = 3'd4,
        S_DONE = 3'd5,
        S_ERR  = 3'd6
    } state_t;

    localparam logic [15:0] c_depth = 16'(DEPTH);

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_t c_data_end = S_CSUM;
`else
    localparam state_t c_data_end = S_DONE;
`endif

    state_t           r_state;
    logic [15:0]      r_count;
    logic [15:0]      r_index;
    logic [1:0]       r_lane;
    logic [23:0]      r_lanes;
    logic             r_wr_en;
    logic [WIDTH-1:0] r_wr_addr;
    logic [WIDTH-1:0] r_wr_data;
    logic             r_hold;
    logic             r_err;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]       r_sum;
`endif

    logic             w_take;
    logic [15:0]      w_count;
    logic [15:0]      w_index_nxt;

    assign in_ready    = (r_state == S_HDR0) || (r_state == S_HDR1) ||
                         (r_state == S_DATA) || (r_state == S_CSUM);
    assign w_take      = in_valid && in_ready;
    assign w_count     = {in_data, r_count[7:0]};
    assign w_index_nxt = r_index + 16'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_count   <= '0;
            r_index   <= '0;
            r_lane    <= '0;
            r_lanes   <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_hold    <= 1'b0;
            r_err     <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_sum     <= '0;
`endif
        end else begin
            r_wr_en <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_HDR0;
                        r_err   <= 1'b0;
                        r_hold  <= 1'b1;
                        r_index <= '0;
                        r_lane  <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        r_sum   <= '0;
`endif
                    end
                end
                S_HDR0: begin
                    if (w_take) begin
                        r_count[7:0] <= in_data;
                        r_state      <= S_HDR1;
                    end
                end
                S_HDR1: begin
                    if (w_take) begin
                        r_count[15:8] <= in_data;
                        if (w_count > c_depth) begin
                            r_state <= S_ERR;
                            r_err   <= 1'b1;
                        end else if (w_count == 16'd0) begin
                            r_state <= c_data_end;
                        end else begin
                            r_state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (w_take) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        r_sum <= r_sum + in_data;
`endif
                        // Lanes shift in from the top so three shifts leave {b2,b1,b0}.
                        if (r_lane == 2'd3) begin
                            r_wr_en   <= 1'b1;
                            r_wr_data <= WIDTH'({in_data, r_lanes});
                            r_wr_addr <= WIDTH'({r_index, 2'b00});
                            r_index   <= w_index_nxt;
                            r_lane    <= 2'd0;
                            if (w_index_nxt == r_count) begin
                                r_state <= c_data_end;
                            end
                        end else begin
                            r_lanes <= {in_data, r_lanes[23:8]};
                            r_lane  <= r_lane + 2'd1;
                        end
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                S_CSUM: begin
                    if (w_take) begin
                        if (in_data == r_sum) begin
                            r_state <= S_DONE;
                        end else begin
                            r_state <= S_ERR;
                            r_err   <= 1'b1;
                        end
                    end
                end
`endif
                S_DONE, S_ERR: begin
                    r_state <= S_IDLE;
                    r_hold  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_hold  <= 1'b0;
                end
            endcase
        end
    end

    assign wr_en    = r_wr_en;
    assign wr_addr  = r_wr_addr;
    assign wr_data  = r_wr_data;
    assign cpu_hold = r_hold;
    assign done     = (r_state == S_DONE);
    assign err      = r_err;

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// ============================================================================
// Module  : tb_imem_loader
// Brief   : Vector-table and directed-sequence bench for imem_loader.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_imem_loader;

    localparam int WIDTH = 32;
    localparam int DEPTH = 1024;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam logic c_cs = 1'b1;
`else
    localparam logic c_cs = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             in_valid = 1'b0;
    logic [7:0]       in_data = 8'h00;
    logic             in_ready;
    logic             wr_en;
    logic [WIDTH-1:0] wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic             cpu_hold;
    logic             done;
    logic             err;

    int n_vec = 0;
    int n_bad = 0;

    imem_loader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .cpu_hold (cpu_hold),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic        start;
        logic        in_valid;
        logic [7:0]  in_data;
        logic        e_ready;
        logic        e_wen;
        logic [31:0] e_addr;
        logic [31:0] e_data;
        logic        e_hold;
        logic        e_done;
        logic        e_err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rn, input logic st, input logic v,
                                input logic [7:0] d, input logic rdy, input logic wen,
                                input logic [31:0] addr, input logic [31:0] data,
                                input logic hold, input logic dn, input logic er);
        vec_t r;
        r.rst_n = rn;  r.start = st;   r.in_valid = v;   r.in_data = d;
        r.e_ready = rdy; r.e_wen = wen; r.e_addr = addr; r.e_data = data;
        r.e_hold = hold; r.e_done = dn; r.e_err = er;
        return r;
    endfunction

    // Drive inputs after the falling edge, check outputs 1 time unit later.
    task automatic apply(input vec_t v);
        logic chk_wr;
        logic bad;
        @(negedge clk);
        rst_n    = v.rst_n;
        start    = v.start;
        in_valid = v.in_valid;
        in_data  = v.in_data;
        #1;
        n_vec++;
        chk_wr = v.e_wen || !v.rst_n;
        bad = (in_ready !== v.e_ready) || (wr_en !== v.e_wen) || (cpu_hold !== v.e_hold) ||
              (done !== v.e_done) || (err !== v.e_err) ||
              (chk_wr && ((wr_addr !== v.e_addr) || (wr_data !== v.e_data)));
        if (bad) begin
            n_bad++;
            $display("FAIL vec %0d: got rdy=%b wen=%b addr=%h data=%h hold=%b done=%b err=%b, expected rdy=%b wen=%b addr=%h data=%h hold=%b done=%b err=%b",
                     n_vec, in_ready, wr_en, wr_addr, wr_data, cpu_hold, done, err,
                     v.e_ready, v.e_wen, v.e_addr, v.e_data, v.e_hold, v.e_done, v.e_err);
        end
    endtask

    // Full load with optional random in_valid gaps; expected writes come from the byte list.
    task automatic run_load(input logic [7:0] bytes[$], input int maxgap);
        logic        pend;
        logic [31:0] paddr;
        logic [31:0] pdata;
        int          cnt;
        int          p;
        int          gap;
        pend  = 1'b0;
        paddr = '0;
        pdata = '0;
        cnt   = int'({bytes[1], bytes[0]});
        apply(mk(1, 1, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < bytes.size(); i++) begin
            gap = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
            for (int g = 0; g < gap; g++) begin
                apply(mk(1, 0, 0, 8'h00, 1, pend, paddr, pdata, 1, 0, 0));
                pend = 1'b0;
            end
            apply(mk(1, 0, 1, bytes[i], 1, pend, paddr, pdata, 1, 0, 0));
            pend = 1'b0;
            p = i - 2;
            if (i >= 2 && p < 4 * cnt && (p % 4) == 3) begin
                pend  = 1'b1;
                paddr = 32'((p / 4) * 4);
                pdata = {bytes[i], bytes[i-1], bytes[i-2], bytes[i-3]};
            end
        end
        apply(mk(1, 0, 0, 8'h00, 0, pend, paddr, pdata, 1, 1, 0));
        apply(mk(1, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0));
    endtask

    initial begin
        logic [7:0]  s_small[$];
        logic [7:0]  s_big[$];
        logic [31:0] w;
        logic [7:0]  sum8;

        // Reset, then idle with in_valid held: nothing accepted, nothing written.
        vecs.push_back(mk(0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 8'hFF, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 10; i++)
            vecs.push_back(mk(1, 0, 1, 8'(i + 1), 0, 0, 0, 0, 0, 0, 0));

        // Two-word load, back-to-back bytes.
        vecs.push_back(mk(1, 1, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 1, 8'h02, 1, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(1, 0, 1, 8'h00, 1, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(1, 0, 1, 8'h13, 1, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(1, 0, 1, 8'h00, 1, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(1, 0, 1, 8'h00, 1, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(1, 0, 1, 8'h00, 1, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(1, 0, 1, 8'h93, 1, 1, 32'h0, 32'h0000_0013, 1, 0, 0));
        vecs.push_back(mk(1, 0, 1, 8'h00, 1, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(1, 0, 1, 8'h10, 1, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(1, 0, 1, 8'h00, 1, 0, 0, 0, 1, 0, 0));
`ifdef IMEM_LOADER_CHECKSUM_EN
        vecs.push_back(mk(1, 0, 1, 8'hB6, 1, 1, 32'h4, 32'h0010_0093, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 8'h00, 0, 0, 0, 0, 1, 1, 0));
`else
        vecs.push_back(mk(1, 0, 0, 8'h00, 0, 1, 32'h4, 32'h0010_0093, 1, 1, 0));
`endif
        vecs.push_back(mk(1, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0));

        // Count 1025 rejected: sticky err, no write, next start clears it.
        vecs.push_back(mk(1, 1, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 1, 8'h01, 1, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(1, 0, 1, 8'h04, 1, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(1, 0, 1, 8'h55, 0, 0, 0, 0, 1, 0, 1));
        vecs.push_back(mk(1, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(1, 1, 0, 8'h00, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(1, 0, 0, 8'h00, 1, 0, 0, 0, 1, 0, 0));

        // Count 0: completes with no write.
        vecs.push_back(mk(1, 0, 1, 8'h00, 1, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(1, 0, 1, 8'h00, 1, 0, 0, 0, 1, 0, 0));
`ifdef IMEM_LOADER_CHECKSUM_EN
        vecs.push_back(mk(1, 0, 1, 8'h00, 1, 0, 0, 0, 1, 0, 0));
`endif
        vecs.push_back(mk(1, 0, 0, 8'h00, 0, 0, 0, 0, 1, 1, 0));
        vecs.push_back(mk(1, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0));

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Bad checksum: both writes still issued, then err.
        vecs.push_back(mk(1, 1, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 1, 8'h02, 1, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(1, 0, 1, 8'h00, 1, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(1, 0, 1, 8'h13, 1, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(1, 0, 1, 8'h00, 1, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(1, 0, 1, 8'h00, 1, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(1, 0, 1, 8'h00, 1, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(1, 0, 1, 8'h93, 1, 1, 32'h0, 32'h0000_0013, 1, 0, 0));
        vecs.push_back(mk(1, 0, 1, 8'h00, 1, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(1, 0, 1, 8'h10, 1, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(1, 0, 1, 8'h00, 1, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(1, 0, 1, 8'hB7, 1, 1, 32'h4, 32'h0010_0093, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 8'h00, 0, 0, 0, 0, 1, 0, 1));
        vecs.push_back(mk(1, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 1));
`endif

        // Reset mid-word: outputs drop immediately and the partial word is never written.
        vecs.push_back(mk(1, 1, 0, 8'h00, 0, 0, 0, 0, 0, 0, c_cs));
        vecs.push_back(mk(1, 0, 1, 8'h01, 1, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(1, 0, 1, 8'h00, 1, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(1, 0, 1, 8'h11, 1, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(1, 0, 1, 8'h22, 1, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 8'h33, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 8'h44, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 1, 8'h55, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 1, 8'h66, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0));

        for (int i = 0; i < vecs.size(); i++)
            apply(vecs[i]);

        // Same two-word stream with random in_valid gaps.
        s_small = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
`ifdef IMEM_LOADER_CHECKSUM_EN
        s_small.push_back(8'hB6);
`endif
        for (int r = 0; r < 3; r++)
            run_load(s_small, 5);

        // Full-depth load: last write lands at 0xFFC.
        s_big = '{8'h00, 8'h04};
        sum8  = 8'h00;
        for (int k = 0; k < DEPTH; k++) begin
            w = 32'hC0DE_0000 | 32'(k);
            for (int j = 0; j < 4; j++) begin
                s_big.push_back(w[8*j +: 8]);
                sum8 = sum8 + w[8*j +: 8];
            end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        s_big.push_back(sum8);
`endif
        run_load(s_big, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
